fetch_sequencer: RTL and testbench

//  Sequences the 16-bit program counter (PC) for instruction fetch in the TTL16 CPU.
//  - Owns PC write strobe W and the writeFromDIN select.
//  - Issues memory read requests at the current PC, latches the returned word into IR,
//    and hands IR to execute over a valid/ready handshake.
//  - Applies branch redirects from execute by loading BR_TARGET into the PC.
//  - Sits between the PC register block, instruction memory and the execute stage.

---
 rtl/fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer_timeout_ctr.sv | 37 +++
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared TTL16 CPU definitions: word width and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [2:0] S_VEC_ENC   = 3'd0;
    localparam logic [2:0] S_REQ_ENC   = 3'd1;
    localparam logic [2:0] S_HOLD_ENC  = 3'd2;
    localparam logic [2:0] S_INC_ENC   = 3'd3;
    localparam logic [2:0] S_BR_ENC    = 3'd4;
    localparam logic [2:0] S_FAULT_ENC = 3'd5;

    typedef enum logic [2:0] {
        S_VEC   = S_VEC_ENC,
        S_REQ   = S_REQ_ENC,
        S_HOLD  = S_HOLD_ENC,
        S_INC   = S_INC_ENC,
        S_BR    = S_BR_ENC,
        S_FAULT = S_FAULT_ENC
    } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch bus bundle: PC register control, instruction memory read port, IR handoff and redirects.
interface fetch_sequencer_if;
    import cpu_pkg::*;

    logic [WORD_W-1:0] PC_DOUT;
    logic [WORD_W-1:0] PC_DIN;
    logic              PC_W;
    logic              PC_WRITE_FROM_DIN;
    logic              MEM_REQ;
    logic [WORD_W-1:0] MEM_ADDR;
    logic              MEM_ACK;
    logic [WORD_W-1:0] MEM_RDATA;
    logic [WORD_W-1:0] IR;
    logic              IR_VALID;
    logic              IR_READY;
    logic              BR_VALID;
    logic [WORD_W-1:0] BR_TARGET;
    logic              HALT;
    logic              FAULT;

    modport master (
        input  PC_DOUT, MEM_ACK, MEM_RDATA, IR_READY, BR_VALID, BR_TARGET, HALT,
        output PC_DIN, PC_W, PC_WRITE_FROM_DIN, MEM_REQ, MEM_ADDR, IR, IR_VALID, FAULT
    );

    modport slave (
        output PC_DOUT, MEM_ACK, MEM_RDATA, IR_READY, BR_VALID, BR_TARGET, HALT,
        input  PC_DIN, PC_W, PC_WRITE_FROM_DIN, MEM_REQ, MEM_ADDR, IR, IR_VALID, FAULT
    );

endinterface

// File: rtl/fetch_sequencer_timeout_ctr.sv
// Counts request cycles without MEM_ACK and flags expiry on the last allowed cycle.
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The request always drops between transactions, so idle cycles restart the count.
    always_comb begin
        cnt_d = cnt_q;
        if (!mem_req) begin
            cnt_d = '0;
        end else if (!mem_ack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = mem_req && !mem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// TTL16 fetch sequencer: drives the external PC register and fetches into IR.
// Optional MEM_ACK watchdog is built when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR   = 16'h0000,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    fetch_sequencer_if.master bus,
    output state_e            dbg_state
);

    // Handshakes: MEM_REQ stays high until the cycle MEM_ACK is sampled high; IR transfers
    // in the cycle IR_VALID && IR_READY are both high; BR_VALID is a one-cycle pulse.

    state_e            state_q,    state_d;
    logic              pc_w_q,     pc_w_d;
    logic              pc_sel_q,   pc_sel_d;
    logic [WORD_W-1:0] pc_din_q,   pc_din_d;
    logic              mem_req_q,  mem_req_d;
    logic [WORD_W-1:0] ir_q,       ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              br_pend_q,  br_pend_d;
    logic [WORD_W-1:0] br_tgt_q,   br_tgt_d;
    logic              fault_q,    fault_d;
    logic              br_take;
    logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst_n   (nRST),
        .mem_req (mem_req_q),
        .mem_ack (bus.MEM_ACK),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign br_take = bus.BR_VALID && (state_q != S_VEC) && (state_q != S_FAULT);

    always_comb begin
        state_d    = state_q;
        pc_w_d     = 1'b0;
        pc_sel_d   = pc_sel_q;
        pc_din_d   = pc_din_q;
        mem_req_d  = mem_req_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_tgt_q;
        fault_d    = fault_q;

        // A later redirect simply replaces the pending target.
        if (br_take) begin
            br_pend_d = 1'b1;
            br_tgt_d  = bus.BR_TARGET;
        end

        case (state_q)
            S_VEC: begin
                pc_w_d   = 1'b1;
                pc_sel_d = 1'b1;
                pc_din_d = RESET_VECTOR;
                state_d  = S_REQ;
            end
            S_REQ: begin
                if (mem_req_q) begin
                    if (bus.MEM_ACK) begin
                        mem_req_d = 1'b0;
                        if (br_pend_q || br_take) begin
                            state_d = S_BR;
                        end else begin
                            ir_d       = bus.MEM_RDATA;
                            ir_valid_d = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end else if (timeout_hit) begin
                        mem_req_d = 1'b0;
                        fault_d   = 1'b1;
                        state_d   = S_FAULT;
                    end
                end else if (br_pend_q || br_take) begin
                    state_d = S_BR;
                end else if (!bus.HALT) begin
                    mem_req_d = 1'b1;
                end
            end
            S_HOLD: begin
                // Branch beats accept: the squashed IR never advances the PC.
                if (br_take) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_BR;
                end else if (bus.IR_READY) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_INC;
                end
            end
            S_INC: begin
                pc_w_d   = 1'b1;
                pc_sel_d = 1'b0;
                state_d  = S_REQ;
            end
            S_BR: begin
                pc_w_d    = 1'b1;
                pc_sel_d  = 1'b1;
                pc_din_d  = bus.BR_VALID ? bus.BR_TARGET : br_tgt_q;
                br_pend_d = 1'b0;
                state_d   = S_REQ;
            end
            S_FAULT: begin
                mem_req_d = 1'b0;
            end
            default: begin
                state_d = S_VEC;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_VEC;
            pc_w_q     <= 1'b0;
            pc_sel_q   <= 1'b0;
            pc_din_q   <= '0;
            mem_req_q  <= 1'b0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_w_q     <= pc_w_d;
            pc_sel_q   <= pc_sel_d;
            pc_din_q   <= pc_din_d;
            mem_req_q  <= mem_req_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            br_pend_q  <= br_pend_d;
            br_tgt_q   <= br_tgt_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.PC_W              = pc_w_q;
    assign bus.PC_WRITE_FROM_DIN = pc_sel_q;
    assign bus.PC_DIN            = pc_din_q;
    assign bus.MEM_REQ           = mem_req_q;
    assign bus.MEM_ADDR          = mem_req_q ? bus.PC_DOUT : '0;
    assign bus.IR                = ir_q;
    assign bus.IR_VALID          = ir_valid_q;
    assign bus.FAULT             = fault_q;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register and memory driver.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    localparam logic [15:0] RV = 16'h0000;

    logic   CLK;
    logic   nRST;
    state_e dbg_state;
    int     n_cmp  = 0;
    int     n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pc_reg = 16'h5A5A;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .RESET_VECTOR   (RV),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // External PC register clocked by its write strobe.
    always @(posedge bus.PC_W) pc_reg <= bus.PC_WRITE_FROM_DIN ? bus.PC_DIN : pc_reg + 16'd1;
    assign bus.PC_DOUT = pc_reg;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 16'h0;
        bus.BR_VALID  = 1'b0;
        bus.BR_TARGET = 16'h0;
        bus.HALT      = 1'b0;
    endtask

    task automatic wait_req(output bit seen);
        int n;
        n = 0;
        while (!bus.MEM_REQ && n < 50) begin
            tick();
            n++;
        end
        seen = bus.MEM_REQ;
    endtask

    // Waits for a request, acks it after ack_delay cycles and returns one cycle after the ack.
    task automatic serve(input logic [15:0] data, input int ack_delay,
                         output bit seen, output logic [15:0] addr, output int waited);
        seen = 1'b0; addr = 16'h0; waited = 0;
        while (!bus.MEM_REQ && waited < 50) begin
            tick();
            waited++;
        end
        if (bus.MEM_REQ) begin
            seen = 1'b1;
            addr = bus.MEM_ADDR;
            repeat (ack_delay) tick();
            bus.MEM_ACK = 1'b1; bus.MEM_RDATA = data;
            tick();
            bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 16'h0;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        bus.IR_READY = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got=%0h exp=0", bus.MEM_REQ); end
        n_cmp++; if (bus.MEM_ADDR !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.MEM_ADDR); end
        n_cmp++; if (bus.PC_W !== 1'b0) begin n_fail++; $display("FAIL rst_pc_w got=%0h exp=0", bus.PC_W); end
        n_cmp++; if (bus.PC_WRITE_FROM_DIN !== 1'b0) begin n_fail++; $display("FAIL rst_pc_sel got=%0h exp=0", bus.PC_WRITE_FROM_DIN); end
        n_cmp++; if (bus.PC_DIN !== 16'h0) begin n_fail++; $display("FAIL rst_pc_din got=%0h exp=0", bus.PC_DIN); end
        n_cmp++; if (bus.IR !== 16'h0) begin n_fail++; $display("FAIL rst_ir got=%0h exp=0", bus.IR); end
        n_cmp++; if (bus.IR_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_ir_valid got=%0h exp=0", bus.IR_VALID); end
        n_cmp++; if (bus.FAULT !== 1'b0) begin n_fail++; $display("FAIL rst_fault got=%0h exp=0", bus.FAULT); end
        n_cmp++; if (dbg_state !== S_VEC) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_VEC); end
        nRST = 1'b1;
    endtask

    task automatic test_sequential();
        bit seen; logic [15:0] addr; int waited; logic [15:0] d; logic [15:0] e;
        bus.IR_READY = 1'b1;
        tick();
        n_cmp++; if (bus.PC_W !== 1'b1) begin n_fail++; $display("FAIL vec_pc_w got=%0h exp=1", bus.PC_W); end
        n_cmp++; if (bus.PC_WRITE_FROM_DIN !== 1'b1) begin n_fail++; $display("FAIL vec_pc_sel got=%0h exp=1", bus.PC_WRITE_FROM_DIN); end
        n_cmp++; if (bus.PC_DIN !== RV) begin n_fail++; $display("FAIL vec_pc_din got=%0h exp=%0h", bus.PC_DIN, RV); end
        n_cmp++; if (pc_reg !== RV) begin n_fail++; $display("FAIL vec_pc got=%0h exp=%0h", pc_reg, RV); end
        n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL vec_mem_req got=%0h exp=0", bus.MEM_REQ); end
        tick();
        n_cmp++; if (bus.PC_W !== 1'b0) begin n_fail++; $display("FAIL vec_pc_w_pulse got=%0h exp=0", bus.PC_W); end
        for (int i = 0; i < 3; i++) begin
            d = 16'hA000 + 16'(i);
            exp_q.push_back(d);
            serve(d, 1, seen, addr, waited);
            e = exp_q.pop_front();
            n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL seq_req_%0d got=%0h exp=1", i, seen); end
            n_cmp++; if (addr !== 16'(i)) begin n_fail++; $display("FAIL seq_addr_%0d got=%0h exp=%0h", i, addr, i); end
            n_cmp++; if (bus.IR !== e) begin n_fail++; $display("FAIL seq_ir_%0d got=%0h exp=%0h", i, bus.IR, e); end
            n_cmp++; if (bus.IR_VALID !== 1'b1) begin n_fail++; $display("FAIL seq_ir_valid_%0d got=%0h exp=1", i, bus.IR_VALID); end
            if (i > 0) begin
                n_cmp++; if (waited !== 3) begin n_fail++; $display("FAIL seq_latency_%0d got=%0d exp=3", i, waited); end
            end
        end
        tick();
    endtask

    task automatic test_stall();
        bit seen; logic [15:0] addr; int waited;
        bus.IR_READY = 1'b0;
        serve(16'hC0DE, 1, seen, addr, waited);
        n_cmp++; if (addr !== 16'h0003) begin n_fail++; $display("FAIL stall_addr got=%0h exp=3", addr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.IR_VALID !== 1'b1) begin n_fail++; $display("FAIL stall_valid_%0d got=%0h exp=1", i, bus.IR_VALID); end
            n_cmp++; if (bus.IR !== 16'hC0DE) begin n_fail++; $display("FAIL stall_ir_%0d got=%0h exp=c0de", i, bus.IR); end
            n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL stall_req_%0d got=%0h exp=0", i, bus.MEM_REQ); end
            n_cmp++; if (pc_reg !== 16'h0003) begin n_fail++; $display("FAIL stall_pc_%0d got=%0h exp=3", i, pc_reg); end
        end
        bus.IR_READY = 1'b1;
        tick();
    endtask

    task automatic test_branch();
        bit seen; logic [15:0] addr; int waited;
        wait_req(seen);
        n_cmp++; if (bus.MEM_ADDR !== 16'h0004) begin n_fail++; $display("FAIL br_pre_addr got=%0h exp=4", bus.MEM_ADDR); end
        bus.BR_VALID = 1'b1; bus.BR_TARGET = 16'h1234;
        tick();
        bus.BR_VALID = 1'b0;
        n_cmp++; if (bus.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL br_req_held got=%0h exp=1", bus.MEM_REQ); end
        tick();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 16'hBAD0;
        tick();
        bus.MEM_ACK = 1'b0;
        n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL br_req_drop got=%0h exp=0", bus.MEM_REQ); end
        n_cmp++; if (bus.IR_VALID !== 1'b0) begin n_fail++; $display("FAIL br_discard got=%0h exp=0", bus.IR_VALID); end
        tick();
        n_cmp++; if (bus.PC_W !== 1'b1) begin n_fail++; $display("FAIL br_pc_w got=%0h exp=1", bus.PC_W); end
        n_cmp++; if (bus.PC_DIN !== 16'h1234) begin n_fail++; $display("FAIL br_pc_din got=%0h exp=1234", bus.PC_DIN); end
        n_cmp++; if (bus.PC_WRITE_FROM_DIN !== 1'b1) begin n_fail++; $display("FAIL br_pc_sel got=%0h exp=1", bus.PC_WRITE_FROM_DIN); end
        serve(16'h1111, 1, seen, addr, waited);
        n_cmp++; if (addr !== 16'h1234) begin n_fail++; $display("FAIL br_addr got=%0h exp=1234", addr); end
        n_cmp++; if (bus.IR !== 16'h1111) begin n_fail++; $display("FAIL br_ir got=%0h exp=1111", bus.IR); end
        // Redirect arrives together with IR_READY.
        bus.BR_VALID = 1'b1; bus.BR_TARGET = 16'h2000;
        tick();
        bus.BR_VALID = 1'b0;
        n_cmp++; if (bus.IR_VALID !== 1'b0) begin n_fail++; $display("FAIL brr_squash got=%0h exp=0", bus.IR_VALID); end
        serve(16'h2222, 1, seen, addr, waited);
        n_cmp++; if (addr !== 16'h2000) begin n_fail++; $display("FAIL brr_addr got=%0h exp=2000", addr); end
        tick();
        // Redirect arrives together with MEM_ACK.
        wait_req(seen);
        n_cmp++; if (bus.MEM_ADDR !== 16'h2001) begin n_fail++; $display("FAIL bra_pre_addr got=%0h exp=2001", bus.MEM_ADDR); end
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 16'hDEAD; bus.BR_VALID = 1'b1; bus.BR_TARGET = 16'h3000;
        tick();
        clear_inputs();
        n_cmp++; if (bus.IR_VALID !== 1'b0) begin n_fail++; $display("FAIL bra_discard got=%0h exp=0", bus.IR_VALID); end
        n_cmp++; if (dbg_state !== S_BR) begin n_fail++; $display("FAIL bra_state got=%0d exp=%0d", dbg_state, S_BR); end
        serve(16'h3333, 1, seen, addr, waited);
        n_cmp++; if (addr !== 16'h3000) begin n_fail++; $display("FAIL bra_addr got=%0h exp=3000", addr); end
        n_cmp++; if (bus.IR !== 16'h3333) begin n_fail++; $display("FAIL bra_ir got=%0h exp=3333", bus.IR); end
    endtask

    task automatic test_wrap();
        bit seen; logic [15:0] addr; int waited;
        bus.BR_VALID = 1'b1; bus.BR_TARGET = 16'hFFFF;
        tick();
        bus.BR_VALID = 1'b0;
        serve(16'h4444, 1, seen, addr, waited);
        n_cmp++; if (addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff got=%0h exp=ffff", addr); end
        serve(16'h5555, 1, seen, addr, waited);
        n_cmp++; if (addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_0000 got=%0h exp=0", addr); end
        n_cmp++; if (waited !== 3) begin n_fail++; $display("FAIL wrap_latency got=%0d exp=3", waited); end
        n_cmp++; if (bus.FAULT !== 1'b0) begin n_fail++; $display("FAIL wrap_fault got=%0h exp=0", bus.FAULT); end
    endtask

    task automatic test_halt();
        bit seen;
        bus.HALT = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL halt_req_%0d got=%0h exp=0", i, bus.MEM_REQ); end
            n_cmp++; if (pc_reg !== 16'h0001) begin n_fail++; $display("FAIL halt_pc_%0d got=%0h exp=1", i, pc_reg); end
        end
        n_cmp++; if (dbg_state !== S_REQ) begin n_fail++; $display("FAIL halt_state got=%0d exp=%0d", dbg_state, S_REQ); end
        bus.HALT = 1'b0;
        wait_req(seen);
        n_cmp++; if (bus.MEM_ADDR !== 16'h0001) begin n_fail++; $display("FAIL halt_resume_addr got=%0h exp=1", bus.MEM_ADDR); end
        bus.HALT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL halt_keep_req_%0d got=%0h exp=1", i, bus.MEM_REQ); end
        end
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 16'h6666;
        tick();
        bus.MEM_ACK = 1'b0;
        n_cmp++; if (bus.IR_VALID !== 1'b1) begin n_fail++; $display("FAIL halt_ir_valid got=%0h exp=1", bus.IR_VALID); end
        n_cmp++; if (bus.IR !== 16'h6666) begin n_fail++; $display("FAIL halt_ir got=%0h exp=6666", bus.IR); end
        bus.HALT = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen; logic [15:0] addr; int waited;
        wait_req(seen);
        n_cmp++; if (bus.MEM_ADDR !== 16'h0002) begin n_fail++; $display("FAIL rmid_pre_addr got=%0h exp=2", bus.MEM_ADDR); end
        nRST = 1'b0;
        #1;
        n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rmid_req got=%0h exp=0", bus.MEM_REQ); end
        n_cmp++; if (bus.IR !== 16'h0) begin n_fail++; $display("FAIL rmid_ir got=%0h exp=0", bus.IR); end
        n_cmp++; if (bus.IR_VALID !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%0h exp=0", bus.IR_VALID); end
        n_cmp++; if (dbg_state !== S_VEC) begin n_fail++; $display("FAIL rmid_state got=%0d exp=%0d", dbg_state, S_VEC); end
        repeat (2) tick();
        nRST = 1'b1;
        serve(16'h7777, 1, seen, addr, waited);
        n_cmp++; if (addr !== RV) begin n_fail++; $display("FAIL rmid_addr got=%0h exp=%0h", addr, RV); end
        n_cmp++; if (waited !== 2) begin n_fail++; $display("FAIL rmid_latency got=%0d exp=2", waited); end
        n_cmp++; if (bus.IR !== 16'h7777) begin n_fail++; $display("FAIL rmid_ir2 got=%0h exp=7777", bus.IR); end
        tick();
    endtask

    task automatic test_timeout();
        bit seen; int n;
        wait_req(seen);
        n = 0;
        while (bus.MEM_REQ && n < 40) begin
            n++;
            tick();
        end
`ifdef FETCH_TIMEOUT_EN
        n_cmp++; if (n !== 15) begin n_fail++; $display("FAIL to_cycles got=%0d exp=15", n); end
        n_cmp++; if (bus.FAULT !== 1'b1) begin n_fail++; $display("FAIL to_fault got=%0h exp=1", bus.FAULT); end
        n_cmp++; if (dbg_state !== S_FAULT) begin n_fail++; $display("FAIL to_state got=%0d exp=%0d", dbg_state, S_FAULT); end
        repeat (3) tick();
        n_cmp++; if (bus.FAULT !== 1'b1) begin n_fail++; $display("FAIL to_sticky got=%0h exp=1", bus.FAULT); end
        n_cmp++; if (bus.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL to_req got=%0h exp=0", bus.MEM_REQ); end
`else
        n_cmp++; if (n !== 40) begin n_fail++; $display("FAIL to_wait got=%0d exp=40", n); end
        n_cmp++; if (bus.FAULT !== 1'b0) begin n_fail++; $display("FAIL to_fault got=%0h exp=0", bus.FAULT); end
        n_cmp++; if (bus.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL to_req got=%0h exp=1", bus.MEM_REQ); end
`endif
        nRST = 1'b0;
        #1;
        n_cmp++; if (bus.FAULT !== 1'b0) begin n_fail++; $display("FAIL to_clear got=%0h exp=0", bus.FAULT); end
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        bus.IR_READY = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_timeout();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
